// File: rtl/dmio_access_pkg.sv
// Shared encodings and helpers for the DMIO access master: transfer sizes,
// controller states, IO region base and the byte-lane enable function.
package dmio_access_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [63:0] IO_BASE_DEFAULT = 64'h1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } dmioState_e;

    // Byte-enable for a naturally aligned access of 2^size bytes at lane off.
    function automatic logic [7:0] laneMask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/dmio_lane_unit.sv
// Combinational byte-lane datapath: extracts and extends load fields from a
// 64-bit line, and merges store bytes into a line for read-modify-write.
module dmio_lane_unit
    import dmio_access_pkg::*;
(
    input  logic [63:0] line,
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    input  logic        isSigned,
    input  logic [63:0] wdata,
    output logic [63:0] loadData,
    output logic [63:0] mergedLine
);

    logic [63:0] shifted;
    logic [63:0] wdataShifted;
    logic [7:0]  mask;

    always_comb begin
        shifted      = line >> {off, 3'b000};
        wdataShifted = wdata << {off, 3'b000};
        mask         = laneMask(size, off);

        case (size)
            SZ_B:    loadData = {{56{isSigned & shifted[7]}},  shifted[7:0]};
            SZ_H:    loadData = {{48{isSigned & shifted[15]}}, shifted[15:0]};
            SZ_W:    loadData = {{32{isSigned & shifted[31]}}, shifted[31:0]};
            default: loadData = shifted;
        endcase

        // NOTE: default first so every bit of a combinational output is always written; no latch.
        mergedLine = line;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                mergedLine[i*8 +: 8] = wdataShifted[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dmio_access_master.sv
// Initiator for the DMIO data-memory/IO port: takes core load/store requests,
// runs the DMIO read and/or write cycle and returns a response.
module dmio_access_master
    import dmio_access_pkg::*;
#(
    parameter int                ADDR_W  = 64,
    parameter int                DATA_W  = 64,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] direccion,
    output logic [DATA_W-1:0] dataWrite,
    output logic              memWr,
    input  logic [DATA_W-1:0] dataRead
);

    dmioState_e        state, stateNext;
    logic [ADDR_W-1:0] addrQ;
    logic [1:0]        sizeQ;
    logic              writeQ, signedQ, errQ;
    logic [DATA_W-1:0] wdataQ, lineQ;

    logic              accept, misaligned, illegalIo;
    logic [DATA_W-1:0] loadData, mergedLine;
    logic [ADDR_W-1:0] alignedAddr;

    assign accept      = req_valid & req_ready;
    assign alignedAddr = {addrQ[ADDR_W-1:3], 3'b000};
    assign illegalIo   = (req_addr >= IO_BASE) && (req_size != SZ_D);

    always_comb begin
        case (req_size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = req_addr[0];
            SZ_W:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrQ   <= '0;
            sizeQ   <= SZ_B;
            writeQ  <= 1'b0;
            signedQ <= 1'b0;
            errQ    <= 1'b0;
            wdataQ  <= '0;
            lineQ   <= '0;
        end else begin
            if (accept) begin
                addrQ   <= req_addr;
                sizeQ   <= req_size;
                writeQ  <= req_write;
                signedQ <= req_signed;
                errQ    <= misaligned | illegalIo;
                wdataQ  <= req_wdata;
            end
            if (state == RD) begin
                lineQ <= dataRead;
            end
        end
    end

    dmio_lane_unit u_lane (
        .line       (lineQ),
        .off        (addrQ[2:0]),
        .size       (sizeQ),
        .isSigned   (signedQ),
        .wdata      (wdataQ),
        .loadData   (loadData),
        .mergedLine (mergedLine)
    );

    // memWr is decoded from state, so an async reset drops it immediately.
    always_comb begin
        stateNext  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        direccion  = '0;
        dataWrite  = '0;
        memWr      = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned || illegalIo) begin
                        stateNext = RESP;
                    end else if (req_write && (req_size == SZ_D)) begin
                        stateNext = WR;
                    end else begin
                        stateNext = RD;
                    end
                end
            end
            RD: begin
                direccion = alignedAddr;
                stateNext = writeQ ? WR : RESP;
            end
            WR: begin
                direccion = alignedAddr;
                dataWrite = mergedLine;
                memWr     = 1'b1;
                stateNext = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = errQ;
                resp_rdata = (errQ || writeQ) ? '0 : loadData;
                if (resp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmio_access_master.sv
// Self-checking bench for dmio_access_master: directed scenarios plus random
// loads/stores against a byte-level reference memory model.
module tb_dmio_access_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [63:0] resp_rdata, direccion, dataWrite, dataRead;
    logic        memWr;

    logic [63:0] mem    [0:127];
    logic [63:0] refMem [0:127];
    logic        preloadEn = 1'b0;
    logic [6:0]  preloadIdx = '0;
    logic [63:0] preloadData = '0;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    dmio_access_master dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .direccion  (direccion),
        .dataWrite  (dataWrite),
        .memWr      (memWr),
        .dataRead   (dataRead)
    );

    // Line store covers 0x000-0x1FF and the IO window 0x1000-0x11FF.
    function automatic logic [6:0] memIdx(input logic [63:0] a);
        return {a[12], a[8:3]};
    endfunction

    assign dataRead = mem[memIdx(direccion)];

    always @(posedge clk) begin
        if (memWr) mem[memIdx(direccion)] <= dataWrite;
        else if (preloadEn) mem[preloadIdx] <= preloadData;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        preloadEn   = 1'b1;
        preloadIdx  = memIdx(a);
        preloadData = d;
        @(negedge clk);
        preloadEn   = 1'b0;
        refMem[memIdx(a)] = d;
    endtask

    task automatic doReq(input bit wr, input logic [1:0] sz, input bit sg, input logic [63:0] a,
                         input logic [63:0] wd, input int hold,
                         output logic [63:0] gotData, output logic gotErr);
        int          nb;
        int          off;
        int          lat;
        int          wrCnt;
        int          expLat;
        bit          expErr;
        logic [63:0] line, expLine, expData;

        nb      = 1 << sz;
        off     = int'(a[2:0]);
        expErr  = ((a % 64'(nb)) != 0) || ((a >= 64'h1000) && (sz != 2'd3));
        line    = refMem[memIdx(a)];
        expLine = line;
        expData = '0;
        if (!expErr && wr) begin
            for (int b = 0; b < nb; b++) expLine[(off+b)*8 +: 8] = wd[b*8 +: 8];
        end
        if (!expErr && !wr) begin
            for (int b = 0; b < nb; b++) expData[b*8 +: 8] = line[(off+b)*8 +: 8];
            if (sg && nb < 8 && expData[nb*8-1]) begin
                for (int b = nb; b < 8; b++) expData[b*8 +: 8] = 8'hFF;
            end
        end
        expLat = expErr ? 1 : (!wr ? 2 : (sz == 2'd3 ? 2 : 3));

        @(negedge clk);
        check("req_ready idle", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_size  = 2'($urandom);

        lat   = 1;
        wrCnt = 0;
        while (!resp_valid && lat < 10) begin
            check("req_ready busy", 64'(req_ready), 64'd0);
            if (memWr) begin
                wrCnt++;
                check("direccion", direccion, {a[63:3], 3'b000});
                check("dataWrite", dataWrite, expLine);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(expLat));
        gotData = resp_rdata;
        gotErr  = resp_err;
        if (!resp_valid) begin
            resp_ready = 1'b0;
            return;
        end
        check("memWr count", 64'(wrCnt), (expErr || !wr) ? 64'd0 : 64'd1);
        check("resp_err", 64'(resp_err), 64'(expErr));
        check("resp_rdata", resp_rdata, expData);
        check("resp idle bus", {memWr, direccion[62:0]}, 64'd0);

        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check("hold resp_valid", 64'(resp_valid), 64'd1);
            check("hold resp_rdata", resp_rdata, expData);
            check("hold resp_err", 64'(resp_err), 64'(expErr));
        end
        if (hold > 0) resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("resp_valid drop", 64'(resp_valid), 64'd0);
        check("req_ready after resp", 64'(req_ready), 64'd1);

        if (!expErr && wr) refMem[memIdx(a)] = expLine;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic        e;
        logic [1:0]  sz;
        logic [63:0] addr;
        int          waitCnt;

        #12;
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset resp_err", 64'(resp_err), 64'd0);
        check("reset resp_rdata", resp_rdata, 64'd0);
        check("reset direccion", direccion, 64'd0);
        check("reset dataWrite", dataWrite, 64'd0);
        check("reset memWr", 64'(memWr), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 128; i++) begin
            preload({51'd0, i[6], 3'd0, i[5:0], 3'd0}, {$urandom, $urandom});
        end

        doReq(1'b1, 2'd3, 1'b0, 64'h40, 64'hDEADBEEF_01234567, 0, d, e);
        check("dword store err", 64'(e), 64'd0);

        preload(64'h40, 64'h00000000_80FF0000);
        doReq(1'b0, 2'd0, 1'b1, 64'h45, 64'd0, 0, d, e);
        check("sbyte off5", d, 64'd0);
        doReq(1'b0, 2'd0, 1'b1, 64'h42, 64'd0, 1, d, e);
        check("sbyte off2", d, 64'hFFFFFFFF_FFFFFFFF);
        doReq(1'b0, 2'd0, 1'b0, 64'h42, 64'd0, 0, d, e);
        check("ubyte off2", d, 64'hFF);

        preload(64'h40, 64'h11223344_55667788);
        doReq(1'b1, 2'd1, 1'b0, 64'h42, 64'hABCD, 0, d, e);
        doReq(1'b0, 2'd3, 1'b0, 64'h40, 64'd0, 0, d, e);
        check("half rmw line", d, 64'h11223344_ABCD7788);

        doReq(1'b0, 2'd2, 1'b0, 64'h46, 64'd0, 3, d, e);
        check("misaligned err", 64'(e), 64'd1);

        doReq(1'b1, 2'd3, 1'b0, 64'h1000, 64'hA, 0, d, e);
        check("io dword err", 64'(e), 64'd0);
        doReq(1'b1, 2'd0, 1'b0, 64'h1000, 64'h55, 2, d, e);
        check("io byte err", 64'(e), 64'd1);

        // Reset in the write cycle of a read-modify-write store.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd1;
        req_addr  = 64'h82;
        req_wdata = 64'h1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        waitCnt = 0;
        while (!memWr && waitCnt < 10) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        check("reset-test memWr seen", 64'(memWr), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst memWr drop", 64'(memWr), 64'd0);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst dataWrite", dataWrite, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("post-rst no resp", 64'(resp_valid), 64'd0);
        end
        doReq(1'b0, 2'd3, 1'b0, 64'h80, 64'd0, 0, d, e);

        doReq(1'b0, 2'd1, 1'b1, 64'h44, 64'd0, 3, d, e);

        for (int n = 0; n < 300; n++) begin
            sz   = 2'($urandom_range(0, 3));
            addr = ($urandom_range(0, 3) == 0) ? 64'h1000 : 64'h0;
            addr = addr + 64'($urandom_range(0, 'h1FF));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
            doReq(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
                  {$urandom, $urandom}, int'($urandom_range(0, 2)), d, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
